// File: rtl/card_decoder_seq.sv
// card_decoder_seq: FIFO-buffered card index decoder producing suit/rank by iterative subtraction.
// Define CARD_DUP_CHECK_EN to build the dealt-card bitmap that drives card_dup.
module card_decoder_seq #(
  parameter int unsigned RANKS      = 13,
  parameter int unsigned SUITS      = 4,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned SUIT_W     = 2,
  parameter int unsigned RANK_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  card_bit,
  input  logic              activate,
  output logic              card_ready,
  output logic [SUIT_W-1:0] card_flower,
  output logic [RANK_W-1:0] card_number,
  output logic              card_valid,
  input  logic              card_accept,
  output logic              card_error,
  output logic              card_dup,
  input  logic              clear_deck,
  output logic              busy,
  output logic              work_done_card_processor
);
  localparam int unsigned DECK  = SUITS * RANKS;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DIVIDE, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop;
  logic [IDX_W-1:0] head, rem;
  logic [SUIT_W:0]  q;
  logic             err, head_err, res_wr, res_ok;

  assign card_ready = (count != (PTR_W+1)'(FIFO_DEPTH));
  assign push       = activate & card_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head       = mem[rd_ptr];
  // Extra bit lets the range check work even when DECK == 2**IDX_W.
  assign head_err   = ({1'b0, head} >= (IDX_W+1)'(DECK));
  assign res_wr     = (state == DIVIDE) && (err || (rem < IDX_W'(RANKS)));
  assign res_ok     = res_wr && !err;
  assign busy       = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= card_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= IDLE;
      rem                      <= '0;
      q                        <= '0;
      err                      <= 1'b0;
      card_valid               <= 1'b0;
      card_error               <= 1'b0;
      card_flower              <= '0;
      card_number              <= '0;
      work_done_card_processor <= 1'b0;
    end else begin
      work_done_card_processor <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            rem   <= head;
            q     <= '0;
            err   <= head_err;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (err) begin
            card_flower              <= '0;
            card_number              <= '0;
            card_error               <= 1'b1;
            card_valid               <= 1'b1;
            work_done_card_processor <= 1'b1;
            state                    <= HOLD;
          end else if (rem >= IDX_W'(RANKS)) begin
            rem <= rem - IDX_W'(RANKS);
            q   <= q + 1'b1;
          end else begin
            card_flower              <= q[SUIT_W-1:0];
            card_number              <= rem[RANK_W-1:0];
            card_error               <= 1'b0;
            card_valid               <= 1'b1;
            work_done_card_processor <= 1'b1;
            state                    <= HOLD;
          end
        end
        HOLD: begin
          if (card_accept) begin
            card_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CARD_DUP_CHECK_EN
  logic [DECK-1:0]  dealt;
  logic [IDX_W-1:0] idx;
  logic             dup_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dealt <= '0;
      idx   <= '0;
      dup_q <= 1'b0;
    end else begin
      if (pop)    idx   <= head;
      if (res_wr) dup_q <= res_ok && dealt[idx];
      // Clear takes priority over marking a card written on the same edge.
      if (clear_deck)  dealt      <= '0;
      else if (res_ok) dealt[idx] <= 1'b1;
    end
  end

  assign card_dup = dup_q;
`else
  logic unused_clear;
  logic unused_res_ok;
  assign unused_clear  = clear_deck;
  assign unused_res_ok = res_ok;
  assign card_dup      = 1'b0;
`endif

endmodule

// File: tb/tb_card_decoder_seq.sv
// Self-checking bench for card_decoder_seq: vector table, hand-written corner sequences,
// and random cards checked against a divide/modulo reference model with a dealt-card array.
`timescale 1ns/1ps
module tb_card_decoder_seq;
  localparam int unsigned RANKS      = 13;
  localparam int unsigned SUITS      = 4;
  localparam int unsigned IDX_W      = 6;
  localparam int unsigned SUIT_W     = 2;
  localparam int unsigned RANK_W     = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DECK       = SUITS * RANKS;
`ifdef CARD_DUP_CHECK_EN
  localparam int DUP_EN = 1;
`else
  localparam int DUP_EN = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [IDX_W-1:0]  card_bit;
  logic              activate;
  logic              card_ready;
  logic [SUIT_W-1:0] card_flower;
  logic [RANK_W-1:0] card_number;
  logic              card_valid;
  logic              card_accept;
  logic              card_error;
  logic              card_dup;
  logic              clear_deck;
  logic              busy;
  logic              work_done_card_processor;

  always #5 clk = ~clk;

  card_decoder_seq #(
    .RANKS(RANKS), .SUITS(SUITS), .IDX_W(IDX_W),
    .SUIT_W(SUIT_W), .RANK_W(RANK_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .card_bit(card_bit), .activate(activate),
    .card_ready(card_ready), .card_flower(card_flower), .card_number(card_number),
    .card_valid(card_valid), .card_accept(card_accept), .card_error(card_error),
    .card_dup(card_dup), .clear_deck(clear_deck), .busy(busy),
    .work_done_card_processor(work_done_card_processor)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  bit          dealt [DECK];

  typedef struct {
    int card;
    int flower;
    int number;
    int err;
    int lat;
    int hold;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void model_clear();
    foreach (dealt[i]) dealt[i] = 1'b0;
  endfunction

  // Reference: suit = idx / RANKS, rank = idx % RANKS, latency = suit + 2.
  function automatic void model(input int c, output int f, output int n,
                                output int e, output int d, output int lat);
    if (c >= int'(DECK)) begin
      f = 0; n = 0; e = 1; d = 0; lat = 2;
    end else begin
      f = c / int'(RANKS);
      n = c % int'(RANKS);
      e = 0;
      lat = f + 2;
      d = (DUP_EN != 0) ? int'(dealt[c]) : 0;
      dealt[c] = 1'b1;
    end
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},  int'(card_valid), 0);
    chk({tag, "_error"},  int'(card_error), 0);
    chk({tag, "_dup"},    int'(card_dup), 0);
    chk({tag, "_flower"}, int'(card_flower), 0);
    chk({tag, "_number"}, int'(card_number), 0);
    chk({tag, "_wdone"},  int'(work_done_card_processor), 0);
    chk({tag, "_busy"},   int'(busy), 0);
    chk({tag, "_ready"},  int'(card_ready), 1);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_deck = 1'b1;
    @(negedge clk);
    clear_deck = 1'b0;
    model_clear();
  endtask

  // Pushes one card into an idle DUT, measures latency, checks result, holds, consumes.
  task automatic deal(input string tag, input int c, input int ef, input int en,
                      input int ee, input int ed, input int elat, input int hold);
    int cyc;
    bit seen;
    @(negedge clk);
    card_accept = 1'b1;
    activate    = 1'b1;
    card_bit    = IDX_W'(c);
    @(negedge clk);
    activate = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (card_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_lat"},    cyc, elat);
    chk({tag, "_flower"}, int'(card_flower), ef);
    chk({tag, "_number"}, int'(card_number), en);
    chk({tag, "_error"},  int'(card_error), ee);
    chk({tag, "_dup"},    int'(card_dup), ed);
    chk({tag, "_wdone"},  int'(work_done_card_processor), 1);
    card_accept = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"},  int'(card_valid), 1);
      chk({tag, "_hold_flower"}, int'(card_flower), ef);
      chk({tag, "_hold_wdone"},  int'(work_done_card_processor), 0);
    end
    card_accept = 1'b1;
    @(negedge clk);
    chk({tag, "_consumed"}, int'(card_valid), 0);
  endtask

  vec_t vecs [8];
  int   bp_cards [6] = '{13, 26, 39, 0, 5, 50};
  int   bp_f     [6] = '{1, 2, 3, 0, 0, 3};
  int   bp_n     [6] = '{0, 0, 0, 0, 5, 11};

  initial begin
    int f, n, e, d, lat, got, c, hold;
    int bp_d [6];
    bit cap;

    vecs[0] = '{card: 0,  flower: 0, number: 0,  err: 0, lat: 2, hold: 0};
    vecs[1] = '{card: 51, flower: 3, number: 12, err: 0, lat: 5, hold: 2};
    vecs[2] = '{card: 52, flower: 0, number: 0,  err: 1, lat: 2, hold: 0};
    vecs[3] = '{card: 63, flower: 0, number: 0,  err: 1, lat: 2, hold: 1};
    vecs[4] = '{card: 13, flower: 1, number: 0,  err: 0, lat: 3, hold: 0};
    vecs[5] = '{card: 26, flower: 2, number: 0,  err: 0, lat: 4, hold: 0};
    vecs[6] = '{card: 12, flower: 0, number: 12, err: 0, lat: 2, hold: 0};
    vecs[7] = '{card: 38, flower: 2, number: 12, err: 0, lat: 4, hold: 3};

    rst_n = 1'b0; activate = 1'b0; card_bit = '0;
    card_accept = 1'b1; clear_deck = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      model(vecs[i].card, f, n, e, d, lat);
      deal($sformatf("vec%0d", i), vecs[i].card, vecs[i].flower, vecs[i].number,
           vecs[i].err, d, vecs[i].lat, vecs[i].hold);
    end

    // Duplicate detection and deck clear.
    model(27, f, n, e, d, lat);
    deal("dup_first", 27, 2, 1, 0, 0, 4, 0);
    model(27, f, n, e, d, lat);
    deal("dup_second", 27, 2, 1, 0, DUP_EN, 4, 0);
    pulse_clear();
    model(27, f, n, e, d, lat);
    deal("dup_cleared", 27, 2, 1, 0, 0, 4, 0);

    // Back-pressure: fill FIFO behind a held result, then drain in order.
    for (int i = 0; i < 6; i++) model(bp_cards[i], f, n, e, bp_d[i], lat);
    @(negedge clk);
    card_accept = 1'b0;
    for (int i = 0; i < 5; i++) begin
      activate = 1'b1;
      card_bit = IDX_W'(bp_cards[i]);
      @(negedge clk);
    end
    chk("bp_ready_low", int'(card_ready), 0);
    chk("bp_busy", int'(busy), 1);
    chk("bp_head_valid", int'(card_valid), 1);
    card_bit = IDX_W'(bp_cards[5]);
    repeat (3) @(negedge clk);
    chk("bp_ready_still_low", int'(card_ready), 0);
    chk("bp_head_flower", int'(card_flower), 1);
    card_accept = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
      cap = activate && card_ready;
      if (card_valid) begin
        chk($sformatf("bp%0d_flower", got), int'(card_flower), bp_f[got]);
        chk($sformatf("bp%0d_number", got), int'(card_number), bp_n[got]);
        chk($sformatf("bp%0d_dup", got), int'(card_dup), bp_d[got]);
        got++;
      end
      @(negedge clk);
      if (cap) activate = 1'b0;
    end
    chk("bp_count", got, 6);
    chk("bp_push50", int'(activate), 0);
    activate = 1'b0;

    // Reset in the middle of DIVIDE of card 40 with two cards queued.
    @(negedge clk);
    activate = 1'b1; card_bit = IDX_W'(40);
    @(negedge clk);
    card_bit = IDX_W'(1);
    @(negedge clk);
    card_bit = IDX_W'(2);
    @(negedge clk);
    activate = 1'b0;
    chk("midrst_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    model(7, f, n, e, d, lat);
    deal("post_rst", 7, 0, 7, 0, d, 2, 0);
    repeat (6) @(negedge clk);
    chk("midrst_discard_valid", int'(card_valid), 0);
    chk("midrst_discard_busy", int'(busy), 0);

    // Randomized cards against the reference model.
    for (int i = 0; i < 40; i++) begin
      c = int'($urandom_range(0, 63));
      hold = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) pulse_clear();
      model(c, f, n, e, d, lat);
      deal($sformatf("rnd%0d_c%0d", i, c), c, f, n, e, d, lat, hold);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/card_decoder_seq.md
# card_decoder_seq

Sequential, parametrised card decoder that accepts a stream of card indices, buffers them in a small FIFO, and decodes each into suit (`card_flower`) and rank (`card_number`) using an iterative subtract-by-RANKS divider. It replaces the single-shot combinational suit/rank split in the dealing datapath. It adds input buffering, valid/ready handshakes on both sides, and out-of-range detection. An optional dealt-card bitmap flags duplicate cards.

## Interface
- `RANKS`, 13, ranks per suit (≥2)
- `SUITS`, 4, suits per deck (≥1)
- `IDX_W`, 6, card index width; must satisfy 2^IDX_W ≥ SUITS*RANKS
- `SUIT_W`, 2, `card_flower` width; holds SUITS-1
- `RANK_W`, 4, `card_number` width; holds RANKS-1
- `FIFO_DEPTH`, 4, input FIFO entries; power of two, ≥2
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `card_bit` in IDX_W: card index to decode
- `activate` in 1: input valid; a card is captured on an edge where `activate & card_ready`
- `card_ready` out 1: FIFO not full (combinational from FIFO count)
- `card_flower` out SUIT_W: decoded suit, card_bit / RANKS
- `card_number` out RANK_W: decoded rank, card_bit % RANKS
- `card_valid` out 1: result register holds an unconsumed result
- `card_accept` in 1: downstream ready; the result is consumed on an edge where `card_valid & card_accept`
- `card_error` out 1: the current result came from an index ≥ SUITS*RANKS
- `card_dup` out 1: the current result is a card already dealt since the last clear (0 without macro)
- `clear_deck` in 1: synchronous clear of the dealt-card bitmap
- `busy` out 1: FSM not in IDLE, or FIFO non-empty
- `work_done_card_processor` out 1: one-cycle pulse on the edge a result is written

## Operation
- **FIFO.** Circular buffer with read/write pointers and a count.
  - A push when full cannot occur, because `card_ready` is 0.
  - A push and a pop on the same edge are both performed; the count is unchanged.
- **FSM states:** IDLE, DIVIDE, HOLD.
- **IDLE.**
  - If the FIFO is non-empty, pop into the working registers: `rem` = index, `q` = 0.
  - Set `err` = (index ≥ SUITS*RANKS).
  - Go to DIVIDE.
- **DIVIDE.**
  - If `err` = 1: write the result `flower` = 0, `number` = 0, `card_error` = 1; go to HOLD.
  - Else if `rem` ≥ RANKS: `rem` -= RANKS, `q` += 1; stay in DIVIDE.
  - Else: write the result `flower` = `q`, `number` = `rem[RANK_W-1:0]`, `card_error` = 0; go to HOLD.
- **Result write.** Sets `card_valid` = 1 and pulses `work_done_card_processor`.
- **HOLD.** `card_valid` = 1; outputs are stable until `card_valid & card_accept`. On that edge, clear `card_valid` and go to IDLE.
- **Arithmetic widths.** `rem` is IDX_W wide and `q` is SUIT_W+1 wide. The comparison is unsigned. The subtraction never underflows.
- **Reset (any state, mid-DIVIDE included):**
  - FIFO emptied, FSM to IDLE.
  - `card_valid`, `card_error`, `card_dup`, `card_flower`, `card_number`, `work_done_card_processor` all 0.
  - `busy` = 0; `card_ready` = 1.
  - Bitmap cleared.
  - An in-flight card is discarded.

## Timing
- **Capture to `card_valid`.** Card captured at edge N:
  - Popped at N+1 (if IDLE and it is at the FIFO head).
  - Result written at edge N+2+q, where q = suit.
- **Latency.**
  - Card 0: 2 cycles.
  - Card 51: 5 cycles.
  - Worst case for an in-range card: SUITS+1 cycles.
  - Error card: 2 cycles.
- **Throughput.** Consumption at edge M returns to IDLE; the next pop is at M+1. Best-case spacing is q+3 cycles per card.
- **`card_ready`** falls in the same cycle the count reaches FIFO_DEPTH.
- **`activate` while `card_ready` = 0** is ignored; the upstream holds the card.

## Configuration
- **`CARD_DUP_CHECK_EN` defined:**
  - Adds a SUITS*RANKS-bit dealt bitmap.
  - On an in-range result write: `card_dup` = bitmap[idx]; then bitmap[idx] is set.
  - Error cards never touch the bitmap and get `card_dup` = 0.
  - `clear_deck` zeroes the bitmap. If `clear_deck` coincides with a result write, the clear wins: the bit stays 0, and `card_dup` reflects the pre-clear bit.
- **Undefined:**
  - No bitmap is built.
  - `card_dup` is tied to 0.
  - `clear_deck` is ignored.

## Test plan
- **Single card 0** with `card_accept` = 1: `card_valid` rises 2 cycles after capture; `flower` = 0, `number` = 0; one `work_done` pulse.
- **Card 51:** `flower` = 3, `number` = 12, `card_error` = 0; latency 5 cycles.
- **Card 52, then card 63:** each gives `card_error` = 1, `flower` = 0, `number` = 0; latency 2 cycles; the bitmap is unchanged.
- **Back-pressure.** Hold `card_accept` = 0 and push 13, 26, 39, 0, 5, 50:
  - `card_ready` drops after the FIFO fills (first card in HOLD + 4 buffered).
  - Releasing `card_accept` yields (1,0), (2,0), (3,0), (0,0), (0,5), (3,11) in order; none lost.
- **Duplicate check (`CARD_DUP_CHECK_EN`).** Deal 27 twice: the second result is (2,1) with `card_dup` = 1. Pulse `clear_deck`, deal 27 again: `card_dup` = 0.
- **Reset mid-operation.** Assert `rst_n` = 0 during DIVIDE of card 40 with 2 cards queued:
  - All outputs 0 and `card_ready` = 1 immediately.
  - After release, card 7 decodes to (0,7) with latency 2.
